host_link_controller: RTL and testbench

- Host-side counterpart of the BIP I UART interface; used as an on-board host emulator and as a loopback partner in system benches.
- On a start request it transmits the two BIP I control bytes, 0x01 (hold BIP in reset) then 0x02 (release and run).
- It then receives the four result bytes in order CC low, CC high, ACC low, ACC high, reassembles CC and ACC, and presents them with a one-cycle valid pulse.
- Sits between a uart_tx/uart_rx pair and a result consumer (LEDs, register bank, or bench scoreboard).

---
 rtl/host_link_controller_pkg.sv | 31 +++
 rtl/host_link_controller_edge_detect.sv | 24 ++
 rtl/host_link_controller.sv | 150 +++++++++++++++
 tb/tb_host_link_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_link_controller_pkg.sv
// Shared definitions for the host link controller: one-hot state encodings,
// default BIP I control bytes and the rising-edge convention for done flags.
package host_link_controller_pkg;

    typedef enum logic [7:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_SEND_RST = 8'b0000_0010,
        ST_SEND_RUN = 8'b0000_0100,
        ST_RX_CC_L  = 8'b0000_1000,
        ST_RX_CC_H  = 8'b0001_0000,
        ST_RX_ACC_L = 8'b0010_0000,
        ST_RX_ACC_H = 8'b0100_0000,
        ST_DONE     = 8'b1000_0000
    } state_t;

    localparam logic [7:0] CMD_RESET_DEFAULT = 8'h01;
    localparam logic [7:0] CMD_RUN_DEFAULT   = 8'h02;

    // Done flags are registered once; an event is flag high while the copy is low.
    localparam logic FLAG_RESET_VALUE = 1'b0;

    function automatic logic rising_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic is_rx_state(input state_t s);
        return (s == ST_RX_CC_L) || (s == ST_RX_CC_H) ||
               (s == ST_RX_ACC_L) || (s == ST_RX_ACC_H);
    endfunction

endpackage

// File: rtl/host_link_controller_edge_detect.sv
// Registers a level flag and emits a one-cycle pulse on its rising edge.
// Latency: pulse is combinational in the first cycle the flag is seen high.
module link_edge_detect
    import host_link_controller_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic flag,
    output logic pulse
);

    logic flag_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            flag_q <= FLAG_RESET_VALUE;
        end else begin
            flag_q <= flag;
        end
    end

    assign pulse = rising_edge(flag, flag_q);

endmodule

// File: rtl/host_link_controller.sv
// Host-side BIP I emulator: sends RESET/RUN bytes, reassembles CC and ACC from four rx bytes.
// Result valid 2 cycles after the final rx event; optional rx watchdog under HOST_LINK_TIMEOUT_EN.
module host_link_controller
    import host_link_controller_pkg::*;
#(
    parameter int                     CC_LENGTH      = 11,
    parameter int                     ACC_LENGTH     = 16,
    parameter int                     WORD_LENGTH    = 8,
    parameter logic [WORD_LENGTH-1:0] CMD_RESET      = CMD_RESET_DEFAULT,
    parameter logic [WORD_LENGTH-1:0] CMD_RUN        = CMD_RUN_DEFAULT,
    parameter int                     TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_tx_done,
    input  logic                   i_rx_done,
    input  logic [WORD_LENGTH-1:0] i_data_rx,
    output logic                   o_tx_start,
    output logic [WORD_LENGTH-1:0] o_data_tx,
    output logic                   o_busy,
    output logic                   o_result_valid,
    output logic [CC_LENGTH-1:0]   o_CC,
    output logic [ACC_LENGTH-1:0]  o_ACC,
    output logic                   o_error
);

    if (CC_LENGTH < 9 || CC_LENGTH > 16 || ACC_LENGTH < 9 || ACC_LENGTH > 16 ||
        WORD_LENGTH < 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("host_link_controller: parameter out of range");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic                    tx_evt;
    logic                    rx_evt;
    logic [CC_LENGTH-1:0]    cc_shadow;
    logic [ACC_LENGTH-1:0]   acc_shadow;

    link_edge_detect u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .flag    (i_tx_done),
        .pulse   (tx_evt)
    );

    link_edge_detect u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .flag    (i_rx_done),
        .pulse   (rx_evt)
    );

`ifdef HOST_LINK_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // A byte arriving on the terminal count wins over the watchdog.
    assign tmo_hit = is_rx_state(state) && !rx_evt &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt <= '0;
            o_error <= 1'b0;
        end else begin
            o_error <= tmo_hit;
            if ((state == ST_SEND_RUN && tx_evt) || (is_rx_state(state) && rx_evt)) begin
                tmo_cnt <= '0;
            end else if (is_rx_state(state)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign o_error = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (i_start) state_nxt = ST_SEND_RST;
            ST_SEND_RST: if (tx_evt)  state_nxt = ST_SEND_RUN;
            ST_SEND_RUN: if (tx_evt)  state_nxt = ST_RX_CC_L;
            ST_RX_CC_L:  if (rx_evt)  state_nxt = ST_RX_CC_H;
            ST_RX_CC_H:  if (rx_evt)  state_nxt = ST_RX_ACC_L;
            ST_RX_ACC_L: if (rx_evt)  state_nxt = ST_RX_ACC_H;
            ST_RX_ACC_H: if (rx_evt)  state_nxt = ST_DONE;
            ST_DONE:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
`ifdef HOST_LINK_TIMEOUT_EN
        if (tmo_hit) state_nxt = ST_IDLE;
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign o_tx_start = (state == ST_SEND_RST) || (state == ST_SEND_RUN);
    assign o_busy     = (state != ST_IDLE);

    // The command byte is loaded on entry so it is stable for the whole SEND state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data_tx <= '0;
        end else if (state_nxt == ST_SEND_RST && state == ST_IDLE) begin
            o_data_tx <= CMD_RESET;
        end else if (state_nxt == ST_SEND_RUN && state == ST_SEND_RST) begin
            o_data_tx <= CMD_RUN;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cc_shadow  <= '0;
            acc_shadow <= '0;
        end else if (rx_evt) begin
            case (state)
                ST_RX_CC_L:  cc_shadow[7:0]             <= i_data_rx[7:0];
                ST_RX_CC_H:  cc_shadow[CC_LENGTH-1:8]   <= i_data_rx[CC_LENGTH-9:0];
                ST_RX_ACC_L: acc_shadow[7:0]            <= i_data_rx[7:0];
                ST_RX_ACC_H: acc_shadow[ACC_LENGTH-1:8] <= i_data_rx[ACC_LENGTH-9:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_result_valid <= 1'b0;
            o_CC           <= '0;
            o_ACC          <= '0;
        end else begin
            o_result_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                o_CC  <= cc_shadow;
                o_ACC <= acc_shadow;
            end
        end
    end

endmodule

// File: tb/tb_host_link_controller.sv
// Randomized self-checking bench for host_link_controller against a byte-level result model.
module tb_host_link_controller;

    localparam int CC_L  = 11;
    localparam int ACC_L = 16;
    localparam int TMO   = 50;

    logic              i_clock = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_start = 1'b0;
    logic              i_tx_done = 1'b0;
    logic              i_rx_done = 1'b0;
    logic [7:0]        i_data_rx = 8'h00;
    logic              o_tx_start;
    logic [7:0]        o_data_tx;
    logic              o_busy;
    logic              o_result_valid;
    logic [CC_L-1:0]   o_CC;
    logic [ACC_L-1:0]  o_ACC;
    logic              o_error;

    int vectors     = 0;
    int miscompares = 0;

    logic [CC_L-1:0]  exp_cc  = '0;
    logic [ACC_L-1:0] exp_acc = '0;

    host_link_controller #(
        .CC_LENGTH      (CC_L),
        .ACC_LENGTH     (ACC_L),
        .WORD_LENGTH    (8),
        .CMD_RESET      (8'h01),
        .CMD_RUN        (8'h02),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_tx_done      (i_tx_done),
        .i_rx_done      (i_rx_done),
        .i_data_rx      (i_data_rx),
        .o_tx_start     (o_tx_start),
        .o_data_tx      (o_data_tx),
        .o_busy         (o_busy),
        .o_result_valid (o_result_valid),
        .o_CC           (o_CC),
        .o_ACC          (o_ACC),
        .o_error        (o_error)
    );

    always #5 i_clock = ~i_clock;

    // Result model: little-endian byte pair, truncated to the field width.
    function automatic logic [CC_L-1:0] model_cc(input logic [7:0] lo, input logic [7:0] hi);
        int v;
        v = (int'(hi) * 256 + int'(lo)) % (1 << CC_L);
        return v[CC_L-1:0];
    endfunction

    function automatic logic [ACC_L-1:0] model_acc(input logic [7:0] lo, input logic [7:0] hi);
        int v;
        v = (int'(hi) * 256 + int'(lo)) % (1 << ACC_L);
        return v[ACC_L-1:0];
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic tx_pulse();
        i_tx_done = 1'b1; tick();
        i_tx_done = 1'b0; tick();
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        i_data_rx = b;
        i_rx_done = 1'b1; tick();
        i_rx_done = 1'b0; tick();
    endtask

    task automatic start_pulse();
        i_start = 1'b1; tick();
        i_start = 1'b0;
    endtask

    task automatic front(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        start_pulse();
        tx_pulse();
        tx_pulse();
        rx_pulse(b0);
        rx_pulse(b1);
        rx_pulse(b2);
    endtask

    // Delivers the final byte and observes the following cycles.
    task automatic collect(input logic [7:0] last, input bit start_in_done,
                           output int pulses, output int lat, output logic busy3,
                           output int errs);
        pulses = 0; lat = -1; busy3 = 1'bx; errs = 0;
        i_data_rx = last;
        i_rx_done = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                i_rx_done = 1'b0;
                if (start_in_done) i_start = 1'b1;
            end
            if (k == 2) i_start = 1'b0;
            if (k == 3) busy3 = o_busy;
            if (o_result_valid === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (o_error !== 1'b0) errs++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        tick(); tick();
        vectors++;
        if ({o_tx_start, o_data_tx, o_busy, o_result_valid, o_CC, o_ACC, o_error} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: outputs=%h want 0",
                     {o_tx_start, o_data_tx, o_busy, o_result_valid, o_CC, o_ACC, o_error});
        end
        i_reset = 1'b1;
        tick();
        vectors++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b tx_start=%b want 0 0", o_busy, o_tx_start);
        end
    endtask

    task automatic test_send_sequence();
        int p, l, e;
        logic b3;
        start_pulse();
        vectors++;
        if (o_tx_start !== 1'b1 || o_data_tx !== 8'h01 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL send_rst: tx_start=%b data=%h busy=%b want 1 01 1", o_tx_start, o_data_tx, o_busy);
        end
        i_tx_done = 1'b1; tick();
        vectors++;
        if (o_tx_start !== 1'b1 || o_data_tx !== 8'h02) begin
            miscompares++;
            $display("FAIL send_run: tx_start=%b data=%h want 1 02", o_tx_start, o_data_tx);
        end
        i_tx_done = 1'b0; tick();
        i_tx_done = 1'b1; tick();
        vectors++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_entry: tx_start=%b busy=%b want 0 1", o_tx_start, o_busy);
        end
        i_tx_done = 1'b0; tick();
        rx_pulse(8'hA3); rx_pulse(8'h05); rx_pulse(8'hEF);
        exp_cc = model_cc(8'hA3, 8'h05);
        exp_acc = model_acc(8'hEF, 8'hBE);
        collect(8'hBE, 1'b0, p, l, b3, e);
        vectors++;
        if (p !== 1 || l !== 2) begin
            miscompares++;
            $display("FAIL basic_valid: pulses=%0d latency=%0d want 1 2", p, l);
        end
        vectors++;
        if (o_CC !== 11'h5A3 || o_ACC !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL basic_result: cc=%h acc=%h want 5a3 beef", o_CC, o_ACC);
        end
    endtask

    task automatic test_boundaries();
        int p, l, e;
        logic b3;
        start_pulse();
        rx_pulse(8'h77);
        start_pulse();
        vectors++;
        if (o_tx_start !== 1'b1 || o_data_tx !== 8'h01) begin
            miscompares++;
            $display("FAIL noise_send_rst: tx_start=%b data=%h want 1 01", o_tx_start, o_data_tx);
        end
        tx_pulse();
        // tx and rx together in SEND_RUN: only tx advances
        i_data_rx = 8'h66; i_tx_done = 1'b1; i_rx_done = 1'b1; tick();
        i_tx_done = 1'b0; i_rx_done = 1'b0; tick();
        tx_pulse();
        vectors++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_in_rx: tx_start=%b busy=%b want 0 1", o_tx_start, o_busy);
        end
        rx_pulse(8'hA3);
        i_data_rx = 8'h05; i_tx_done = 1'b1; i_rx_done = 1'b1; tick();
        i_tx_done = 1'b0; i_rx_done = 1'b0; tick();
        rx_pulse(8'hEF);
        start_pulse();
        exp_cc = model_cc(8'hA3, 8'h05);
        exp_acc = model_acc(8'hEF, 8'hBE);
        collect(8'hBE, 1'b1, p, l, b3, e);
        vectors++;
        if (p !== 1 || o_CC !== exp_cc || o_ACC !== exp_acc) begin
            miscompares++;
            $display("FAIL boundary_result: pulses=%0d cc=%h acc=%h want 1 %h %h", p, o_CC, o_ACC, exp_cc, exp_acc);
        end
        vectors++;
        if (b3 !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: busy=%b want 0", b3);
        end
    endtask

    task automatic test_truncate();
        int p, l, e;
        logic b3;
        front(8'h12, 8'hFD, 8'h34);
        exp_cc = model_cc(8'h12, 8'hFD);
        exp_acc = model_acc(8'h34, 8'h56);
        collect(8'h56, 1'b0, p, l, b3, e);
        vectors++;
        if (o_CC[10:8] !== 3'b101 || o_CC !== exp_cc || o_ACC !== exp_acc) begin
            miscompares++;
            $display("FAIL truncate: cc=%h acc=%h want %h %h", o_CC, o_ACC, exp_cc, exp_acc);
        end
    endtask

    task automatic test_async_reset();
        int p, l, e;
        logic b3;
        start_pulse();
        tx_pulse(); tx_pulse();
        rx_pulse(8'h11); rx_pulse(8'h22);
        #2;
        i_reset = 1'b0;
        #1;
        vectors++;
        if ({o_tx_start, o_data_tx, o_busy, o_result_valid, o_CC, o_ACC, o_error} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: outputs=%h want 0",
                     {o_tx_start, o_data_tx, o_busy, o_result_valid, o_CC, o_ACC, o_error});
        end
        exp_cc = '0;
        exp_acc = '0;
        tick();
        i_reset = 1'b1;
        tick();
        front(8'h9C, 8'h07, 8'h01);
        exp_cc = model_cc(8'h9C, 8'h07);
        exp_acc = model_acc(8'h01, 8'h80);
        collect(8'h80, 1'b0, p, l, b3, e);
        vectors++;
        if (p !== 1 || l !== 2 || o_CC !== exp_cc || o_ACC !== exp_acc) begin
            miscompares++;
            $display("FAIL post_reset_run: pulses=%0d lat=%0d cc=%h acc=%h want 1 2 %h %h",
                     p, l, o_CC, o_ACC, exp_cc, exp_acc);
        end
    endtask

    task automatic test_back_to_back();
        int p, l, e;
        logic b3;
        logic [7:0] b [4];
        bit sdone;
        for (int it = 0; it < 16; it++) begin
            for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
            sdone = 1'($urandom_range(0, 1));
            start_pulse();
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 1) == 1) rx_pulse(8'($urandom_range(0, 255)));
            tx_pulse();
            if ($urandom_range(0, 1) == 1) rx_pulse(8'($urandom_range(0, 255)));
            tx_pulse();
            for (int j = 0; j < 3; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                if ($urandom_range(0, 2) == 0) tx_pulse();
                rx_pulse(b[j]);
            end
            vectors++;
            if (o_CC !== exp_cc || o_ACC !== exp_acc) begin
                miscompares++;
                $display("FAIL hold_%0d: cc=%h acc=%h want %h %h", it, o_CC, o_ACC, exp_cc, exp_acc);
            end
            exp_cc = model_cc(b[0], b[1]);
            exp_acc = model_acc(b[2], b[3]);
            collect(b[3], sdone, p, l, b3, e);
            vectors++;
            if (p !== 1 || l !== 2 || b3 !== 1'b0 || e !== 0) begin
                miscompares++;
                $display("FAIL rand_ctl_%0d: pulses=%0d lat=%0d busy=%b err=%0d want 1 2 0 0", it, p, l, b3, e);
            end
            vectors++;
            if (o_CC !== exp_cc || o_ACC !== exp_acc) begin
                miscompares++;
                $display("FAIL rand_res_%0d: cc=%h acc=%h want %h %h", it, o_CC, o_ACC, exp_cc, exp_acc);
            end
        end
    endtask

`ifdef HOST_LINK_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        int pulses;
        int valids;
        logic busy_at;
        first = -1; pulses = 0; valids = 0; busy_at = 1'bx;
        start_pulse();
        tx_pulse(); tx_pulse();
        rx_pulse(8'h44);
        i_data_rx = 8'h55;
        i_rx_done = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) i_rx_done = 1'b0;
            if (o_error === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    busy_at = o_busy;
                end
            end
            if (o_result_valid === 1'b1) valids++;
        end
        vectors++;
        if (first !== 51 || pulses !== 1 || busy_at !== 1'b0 || valids !== 0) begin
            miscompares++;
            $display("FAIL timeout: at=%0d pulses=%0d busy=%b valids=%0d want 51 1 0 0",
                     first, pulses, busy_at, valids);
        end
        vectors++;
        if (o_CC !== exp_cc || o_ACC !== exp_acc) begin
            miscompares++;
            $display("FAIL timeout_hold: cc=%h acc=%h want %h %h", o_CC, o_ACC, exp_cc, exp_acc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_send_sequence();
        test_boundaries();
        test_truncate();
        test_async_reset();
        test_back_to_back();
`ifdef HOST_LINK_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
